// File: rtl/pwm_ramp_ctrl.sv
// Duty/direction sequencer for one PWM motor channel: slew-limited ramping,
// safe reversal through a zero-duty dwell, and a latching emergency stop.
`timescale 1ns/1ps

module pwm_ramp_ctrl #(
   parameter int unsigned RAMP_DIV = 1000,
   parameter int unsigned STEP     = 1,
   parameter int unsigned DWELL    = 500,
   parameter int unsigned DMAX     = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] target,
   input  logic       target_dir,
   input  logic       load,
   input  logic       estop,
   output logic [6:0] duty,
   output logic       dir,
   output logic       busy,
   output logic       at_target
);

   typedef enum logic [1:0] {S_RUN, S_DECEL, S_DWELL, S_STOP} state_t;

   localparam logic [15:0] DIV_LAST   = 16'(RAMP_DIV - 1);
   localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
   localparam logic [7:0]  STEP8      = 8'(STEP);
   localparam logic [6:0]  DMAX7      = 7'(DMAX);

   state_t      state_q, state_d;
   logic [6:0]  cmd_tgt_q, cmd_tgt_d;
   logic        cmd_dir_q, cmd_dir_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] dwell_q, dwell_d;
   logic [6:0]  duty_q, duty_d;
   logic        dir_q, dir_d;
   logic        at_target_q, at_target_d;
   logic        busy_q, busy_d;

   logic        tick;
   logic        take_load;
   logic [6:0]  new_tgt;
   logic [6:0]  eff_tgt;
   logic        eff_dir;

   // One slew-limited step from cur toward tgt; 8-bit math cannot wrap.
   function automatic logic [6:0] ramp_step(input logic [6:0] cur, input logic [6:0] tgt);
      logic [7:0] c8, t8, diff, res;
      c8 = {1'b0, cur};
      t8 = {1'b0, tgt};
      if (t8 > c8) begin
         diff = t8 - c8;
         res  = c8 + ((diff < STEP8) ? diff : STEP8);
      end else begin
         diff = c8 - t8;
         res  = c8 - ((diff < STEP8) ? diff : STEP8);
      end
      return 7'(res);
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      tick      = (presc_q == DIV_LAST);
      presc_d   = tick ? 16'd0 : 16'(presc_q + 16'd1);
      take_load = load && !estop;
      new_tgt   = (target > DMAX7) ? DMAX7 : target;
      // A same-cycle load steers this cycle's decision and step.
      eff_tgt   = take_load ? new_tgt : cmd_tgt_q;
      eff_dir   = take_load ? target_dir : cmd_dir_q;

      state_d   = state_q;
      cmd_tgt_d = eff_tgt;
      cmd_dir_d = eff_dir;
      dwell_d   = dwell_q;
      duty_d    = duty_q;
      dir_d     = dir_q;

      if (estop) begin
         state_d = S_STOP;
         duty_d  = 7'd0;
      end else begin
         unique case (state_q)
            S_RUN: begin
               if (eff_dir == dir_q) begin
                  if (tick) duty_d = ramp_step(duty_q, eff_tgt);
               end else if (duty_q != 7'd0) begin
                  state_d = S_DECEL;
               end else begin
                  dir_d = eff_dir;
               end
            end
            S_DECEL: begin
               if (eff_dir == dir_q) begin
                  state_d = S_RUN;
                  if (tick) duty_d = ramp_step(duty_q, eff_tgt);
               end else begin
                  if (tick) duty_d = ramp_step(duty_q, 7'd0);
                  if (duty_d == 7'd0) begin
                     state_d = S_DWELL;
                     dwell_d = 16'd0;
                  end
               end
            end
            S_DWELL: begin
               if (eff_dir == dir_q) begin
                  state_d = S_RUN;
               end else if (dwell_q == DWELL_LAST) begin
                  dir_d   = eff_dir;
                  state_d = S_RUN;
               end else begin
                  dwell_d = 16'(dwell_q + 16'd1);
               end
            end
            S_STOP: begin
               if (take_load) begin
                  dir_d   = eff_dir;
                  state_d = S_RUN;
                  if (tick) duty_d = ramp_step(duty_q, eff_tgt);
               end
            end
            default: state_d = S_RUN;
         endcase
      end

      at_target_d = (state_d == S_RUN) && (duty_d == cmd_tgt_d) && (dir_d == cmd_dir_d);
      busy_d      = !at_target_d && (state_d != S_STOP);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_RUN;
         cmd_tgt_q   <= 7'd0;
         cmd_dir_q   <= 1'b0;
         presc_q     <= 16'd0;
         dwell_q     <= 16'd0;
         duty_q      <= 7'd0;
         dir_q       <= 1'b0;
         at_target_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_tgt_q   <= cmd_tgt_d;
         cmd_dir_q   <= cmd_dir_d;
         presc_q     <= presc_d;
         dwell_q     <= dwell_d;
         duty_q      <= duty_d;
         dir_q       <= dir_d;
         at_target_q <= at_target_d;
         busy_q      <= busy_d;
      end
   end

   assign duty      = duty_q;
   assign dir       = dir_q;
   assign busy      = busy_q;
   assign at_target = at_target_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: a command-level model predicts the
// sequence of duty/dir changes; a monitor pops and compares each change.
`timescale 1ns/1ps

module tb_pwm_ramp_ctrl;

   localparam int RAMP_DIV = 4;
   localparam int STEP     = 2;
   localparam int DWELL    = 8;
   localparam int DMAX     = 100;

   logic       clk;
   logic       rst;
   logic [6:0] target;
   logic       target_dir;
   logic       load;
   logic       estop;
   logic [6:0] duty;
   logic       dir;
   logic       busy;
   logic       at_target;

   pwm_ramp_ctrl #(
      .RAMP_DIV(RAMP_DIV), .STEP(STEP), .DWELL(DWELL), .DMAX(DMAX)
   ) dut (
      .clk(clk), .rst(rst), .target(target), .target_dir(target_dir),
      .load(load), .estop(estop), .duty(duty), .dir(dir),
      .busy(busy), .at_target(at_target)
   );

   typedef struct {
      int duty;
      bit dir;
      bit at;
      bit busy;
      int gap;   // clocks since previous change; 0 = unchecked
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   last_cyc = 0;
   int   mon_duty = -1;
   bit   mon_en   = 0;
   int   m_duty   = 0;
   bit   m_dir    = 0;
   logic [6:0] prev_duty = 0;
   logic       prev_dir  = 0;

   initial clk = 0;
   always #1 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Monitor: every change of duty/dir is an output event to score.
   always @(negedge clk) begin
      exp_t e;
      if (rst && mon_en && (duty !== prev_duty || dir !== prev_dir)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_change: got duty=%0d dir=%0d expected no change (t=%0t)",
                     duty, dir, $time);
         end else begin
            e = sb.pop_front();
            check("duty", int'(duty), e.duty);
            check("dir", int'(dir), int'(e.dir));
            check("at_target", int'(at_target), int'(e.at));
            check("busy", int'(busy), int'(e.busy));
            if (e.gap != 0) check("step_gap", cyc - last_cyc, e.gap);
         end
         last_cyc = cyc;
         mon_duty = int'(duty);
      end
      prev_duty = duty;
      prev_dir  = dir;
   end

   // Reference model: the list of visible (duty, dir) values a command produces.
   task automatic push_ramp(input int from, input int to, input bit d, input bit final_at);
      int  cur;
      bit  first;
      cur   = from;
      first = 1;
      while (cur != to) begin
         exp_t e;
         int   s;
         s = (to > cur) ? to - cur : cur - to;
         if (s > STEP) s = STEP;
         cur    = (to > cur) ? cur + s : cur - s;
         e.duty = cur;
         e.dir  = d;
         e.at   = final_at && (cur == to);
         e.busy = !e.at;
         e.gap  = first ? 0 : RAMP_DIV;
         sb.push_back(e);
         first = 0;
      end
   endtask

   task automatic push_flip(input bit d, input bit at, input int gap);
      exp_t e;
      e.duty = 0;
      e.dir  = d;
      e.at   = at;
      e.busy = !at;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   task automatic model_cmd(input int tgt, input bit d);
      int tc;
      tc = (tgt > DMAX) ? DMAX : tgt;
      if (d == m_dir) begin
         push_ramp(m_duty, tc, d, 1);
      end else begin
         if (m_duty != 0) begin
            push_ramp(m_duty, 0, m_dir, 0);
            push_flip(d, tc == 0, DWELL);
         end else begin
            push_flip(d, tc == 0, 0);
         end
         push_ramp(0, tc, d, 1);
      end
      m_duty = tc;
      m_dir  = d;
   endtask

   // Called at negedge+0.5; waits for a phase where the load edge is not a tick.
   task automatic wait_safe();
      while (cyc % RAMP_DIV != 0) begin
         @(negedge clk);
         #0.5;
      end
   endtask

   task automatic issue(input int tgt, input bit d);
      int tc;
      bit imm;
      wait_safe();
      tc  = (tgt > DMAX) ? DMAX : tgt;
      imm = (tc == m_duty && d == m_dir) || (m_duty == 0 && tc == 0);
      mon_duty   = -1;
      target     = 7'(tgt);
      target_dir = d;
      load       = 1;
      model_cmd(tgt, d);
      @(negedge clk);
      load = 0;
      #0.5;
      check("busy_after_load", int'(busy), int'(!imm));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(sb.size() == 0 && at_target === 1'b1) && n < 2000) begin
         @(negedge clk);
         #0.5;
         n++;
      end
      if (n >= 2000) begin
         n_checks++;
         n_err++;
         $display("FAIL settle_timeout: got %0d pending changes expected 0", sb.size());
         sb.delete();
      end else begin
         check("settled_duty", int'(duty), m_duty);
         check("settled_dir", int'(dir), int'(m_dir));
      end
   endtask

   task automatic wait_mon_duty(input int v);
      int n;
      n = 0;
      while (mon_duty != v && n < 2000) begin
         @(negedge clk);
         #0.5;
         n++;
      end
      if (n >= 2000) begin
         n_checks++;
         n_err++;
         $display("FAIL wait_duty_timeout: got %0d expected %0d", mon_duty, v);
      end
   endtask

   initial begin
      exp_t e;
      rst        = 0;
      target     = 0;
      target_dir = 0;
      load       = 0;
      estop      = 0;
      #10.5;
      rst = 1;
      @(negedge clk);
      #0.5;
      check("rst_duty", int'(duty), 0);
      check("rst_dir", int'(dir), 0);
      check("rst_at_target", int'(at_target), 1);
      check("rst_busy", int'(busy), 0);
      mon_en = 1;
      repeat (20) @(negedge clk);
      #0.5;
      check("idle_duty", int'(duty), 0);
      check("idle_at_target", int'(at_target), 1);
      check("idle_busy", int'(busy), 0);

      // Accelerate, odd-step decel, clamp, back to 20.
      issue(20, 0);  wait_done();
      issue(7, 0);   wait_done();
      issue(127, 0); wait_done();
      issue(20, 0);  wait_done();

      // Full reversals both ways.
      issue(70, 1);  wait_done();
      issue(20, 0);  wait_done();

      // Abort a reversal while decelerating through 10.
      issue(70, 1);
      wait_mon_duty(10);
      sb.delete();
      m_duty = 10;
      m_dir  = 0;
      issue(30, 0);
      wait_done();

      // Emergency stop at 40, ignored load, then re-arm in the other direction.
      issue(60, 0);
      wait_mon_duty(40);
      estop = 1;
      sb.delete();
      e.duty = 0; e.dir = m_dir; e.at = 0; e.busy = 0; e.gap = 0;
      sb.push_back(e);
      m_duty = 0;
      @(negedge clk);
      #0.5;
      check("estop_duty", int'(duty), 0);
      check("estop_busy", int'(busy), 0);
      target     = 7'd50;
      target_dir = 1;
      load       = 1;
      @(negedge clk);
      load = 0;
      repeat (5) @(negedge clk);
      #0.5;
      check("estop_load_duty", int'(duty), 0);
      check("estop_load_dir", int'(dir), 0);
      estop = 0;
      repeat (3) @(negedge clk);
      #0.5;
      check("stop_held_busy", int'(busy), 0);
      check("stop_held_at_target", int'(at_target), 0);
      check("stop_held_duty", int'(duty), 0);
      issue(30, 1);
      wait_done();

      // Randomized commands from settled states.
      repeat (12) begin
         int t;
         bit d;
         t = int'($urandom_range(0, 127));
         d = 1'($urandom_range(0, 1));
         issue(t, d);
         wait_done();
      end

      // Asynchronous reset in the middle of a ramp.
      issue(40, 1); wait_done();
      issue(90, 1);
      repeat (12) @(negedge clk);
      mon_en = 0;
      @(posedge clk);
      #0.3;
      rst = 0;
      #0.2;
      check("async_rst_duty", int'(duty), 0);
      check("async_rst_dir", int'(dir), 0);
      check("async_rst_at_target", int'(at_target), 1);
      check("async_rst_busy", int'(busy), 0);
      sb.delete();
      #4;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
